// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer for the TDC datapath: launches 2^k pulses, samples the
// popcount a fixed latency after each launch and accumulates sum/min/max.
module tdc_meas_ctrl #(
   parameter  int N       = 64,
   parameter  int LAT     = 4,
   parameter  int LOG_MAX = 8,
   localparam int HW_W    = $clog2(N) + 1,
   localparam int SUM_W   = HW_W + LOG_MAX
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [3:0]       cfg_log2_samples,
   input  logic             cfg_src,
   input  logic             cfg_bypass,
   input  logic             cfg_both_edges,
   output logic             busy,
   output logic             tdc_en,
   output logic             tdc_pg_src,
   output logic             tdc_pg_bypass,
   output logic             tdc_pg_tog,
   input  logic [HW_W-1:0]  tdc_hw,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [SUM_W-1:0] res_sum,
   output logic [HW_W-1:0]  res_min,
   output logic [HW_W-1:0]  res_max
);

   localparam int CNT_W = LOG_MAX + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_LAUNCH,
      S_WAIT,
      S_SAMPLE,
      S_DONE
   } state_e;

   state_e           state_q;
   logic             level_q;
   logic             both_q;
   logic [3:0]       wait_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] target_q;
   logic             busy_q;
   logic             en_q;
   logic             src_q;
   logic             byp_q;
   logic             tog_q;
   logic             valid_q;
   logic [SUM_W-1:0] sum_q;
   logic [HW_W-1:0]  min_q;
   logic [HW_W-1:0]  max_q;

   logic [HW_W-1:0]  eff_d;
   logic             take_d;
   logic [CNT_W-1:0] cnt_d;
   logic [3:0]       k_clamp_d;
   logic [CNT_W-1:0] target_d;
   logic             abort_d;

   // Falling launches see the complement of the rising-edge popcount.
   always_comb begin
      eff_d     = level_q ? tdc_hw : (HW_W'(N) - tdc_hw);
      take_d    = level_q | both_q;
      cnt_d     = cnt_q + CNT_W'(1);
      k_clamp_d = (int'(cfg_log2_samples) > LOG_MAX) ? 4'(LOG_MAX) : cfg_log2_samples;
      target_d  = CNT_W'(1) << k_clamp_d;
      abort_d   = abort && (state_q != S_IDLE) && (state_q != S_DONE);
   end

   // NOTE: every state register uses non-blocking assignment so all of them
   // update together at the edge, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         level_q  <= 1'b0;
         both_q   <= 1'b0;
         wait_q   <= '0;
         cnt_q    <= '0;
         target_q <= '0;
         busy_q   <= 1'b0;
         en_q     <= 1'b0;
         src_q    <= 1'b0;
         byp_q    <= 1'b0;
         tog_q    <= 1'b0;
         valid_q  <= 1'b0;
         sum_q    <= '0;
         min_q    <= '0;
         max_q    <= '0;
      end else begin
         tog_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start && !abort) begin
                  src_q    <= cfg_src;
                  byp_q    <= cfg_bypass;
                  both_q   <= cfg_both_edges;
                  target_q <= target_d;
                  sum_q    <= '0;
                  min_q    <= '1;
                  max_q    <= '0;
                  cnt_q    <= '0;
                  wait_q   <= '0;
                  // The pulse generator restarts from reset, so its level is low.
                  level_q  <= 1'b0;
                  busy_q   <= 1'b1;
                  en_q     <= 1'b1;
                  state_q  <= S_ARM;
               end
            end
            S_ARM: begin
               tog_q   <= 1'b1;
               state_q <= S_LAUNCH;
            end
            S_LAUNCH: begin
               level_q <= ~level_q;
               wait_q  <= 4'd1;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (wait_q == 4'(LAT)) begin
                  state_q <= S_SAMPLE;
               end else begin
                  wait_q <= wait_q + 4'd1;
               end
            end
            S_SAMPLE: begin
               if (take_d) begin
                  sum_q <= sum_q + SUM_W'(eff_d);
                  if (eff_d < min_q) min_q <= eff_d;
                  if (eff_d > max_q) max_q <= eff_d;
                  cnt_q <= cnt_d;
               end
               if (take_d && (cnt_d == target_q)) begin
                  en_q    <= 1'b0;
                  valid_q <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  tog_q   <= 1'b1;
                  state_q <= S_LAUNCH;
               end
            end
            S_DONE: begin
               if (res_ready) begin
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase

         if (abort_d) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
            tog_q   <= 1'b0;
            valid_q <= 1'b0;
         end
      end
   end

   assign busy          = busy_q;
   assign tdc_en        = en_q;
   assign tdc_pg_src    = src_q;
   assign tdc_pg_bypass = byp_q;
   assign tdc_pg_tog    = tog_q;
   assign res_valid     = valid_q;
   assign res_sum       = sum_q;
   assign res_min       = min_q;
   assign res_max       = max_q;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Self-checking bench for tdc_meas_ctrl: a popcount stub that answers exactly
// LAT+1 cycles after each launch, table-driven bursts and a results scoreboard.
module tb_tdc_meas_ctrl;

   localparam int N       = 64;
   localparam int LAT     = 4;
   localparam int LOG_MAX = 8;
   localparam int HW_W    = 7;
   localparam int SUM_W   = HW_W + LOG_MAX;
   localparam logic [HW_W-1:0] GARBAGE = 7'd1;

   typedef struct {
      logic [3:0]       k;
      logic             both;
      logic             src;
      logic             byp;
      logic [HW_W-1:0]  rise [4];
      int               rise_len;
      logic [HW_W-1:0]  fall;
      logic [SUM_W-1:0] sum;
      logic [HW_W-1:0]  mn;
      logic [HW_W-1:0]  mx;
      int               tog;
   } vec_t;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             abort;
   logic [3:0]       cfg_log2_samples;
   logic             cfg_src;
   logic             cfg_bypass;
   logic             cfg_both_edges;
   logic             busy;
   logic             tdc_en;
   logic             tdc_pg_src;
   logic             tdc_pg_bypass;
   logic             tdc_pg_tog;
   logic [HW_W-1:0]  tdc_hw = GARBAGE;
   logic             res_valid;
   logic             res_ready;
   logic [SUM_W-1:0] res_sum;
   logic [HW_W-1:0]  res_min;
   logic [HW_W-1:0]  res_max;

   int n_cmp = 0;
   int n_err = 0;

   tdc_meas_ctrl #(.N(N), .LAT(LAT), .LOG_MAX(LOG_MAX)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start),
      .abort            (abort),
      .cfg_log2_samples (cfg_log2_samples),
      .cfg_src          (cfg_src),
      .cfg_bypass       (cfg_bypass),
      .cfg_both_edges   (cfg_both_edges),
      .busy             (busy),
      .tdc_en           (tdc_en),
      .tdc_pg_src       (tdc_pg_src),
      .tdc_pg_bypass    (tdc_pg_bypass),
      .tdc_pg_tog       (tdc_pg_tog),
      .tdc_hw           (tdc_hw),
      .res_valid        (res_valid),
      .res_ready        (res_ready),
      .res_sum          (res_sum),
      .res_min          (res_min),
      .res_max          (res_max)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stub configuration, written by the test sequence before each start.
   logic [HW_W-1:0] rise_tab [4];
   int              rise_len = 1;
   logic [HW_W-1:0] fall_val = '0;

   // Popcount stub and launch monitor; counters restart when busy rises.
   logic [HW_W-1:0] pipe [LAT+2];
   int  cyc = 0;
   int  last_tog = 0;
   int  tog_cnt = 0;
   int  spacing_err = 0;
   int  launch_cnt = 0;
   int  rise_cnt = 0;
   logic prev_busy = 1'b0;

   initial for (int i = 0; i < LAT + 2; i++) pipe[i] = GARBAGE;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (busy === 1'b1 && prev_busy !== 1'b1) begin
         tog_cnt     = 0;
         spacing_err = 0;
         launch_cnt  = 0;
         rise_cnt    = 0;
      end
      prev_busy = busy;
      for (int i = LAT + 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = GARBAGE;
      if (tdc_pg_tog === 1'b1) begin
         if (tdc_en !== 1'b1) spacing_err = spacing_err + 1;
         if (tog_cnt > 0 && (cyc - last_tog) != LAT + 2) spacing_err = spacing_err + 1;
         last_tog = cyc;
         tog_cnt  = tog_cnt + 1;
         if ((launch_cnt % 2) == 0) begin
            pipe[0]  = rise_tab[rise_cnt % rise_len];
            rise_cnt = rise_cnt + 1;
         end else begin
            pipe[0] = fall_val;
         end
         launch_cnt = launch_cnt + 1;
      end
      tdc_hw = pipe[LAT+1];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic vec_t mk(input int k, input int both, input int src, input int byp,
                               input int r0, input int r1, input int r2, input int r3,
                               input int rlen, input int fall, input int sum,
                               input int mn, input int mx, input int tog);
      vec_t v;
      v.k        = 4'(k);
      v.both     = 1'(both);
      v.src      = 1'(src);
      v.byp      = 1'(byp);
      v.rise[0]  = HW_W'(r0);
      v.rise[1]  = HW_W'(r1);
      v.rise[2]  = HW_W'(r2);
      v.rise[3]  = HW_W'(r3);
      v.rise_len = rlen;
      v.fall     = HW_W'(fall);
      v.sum      = SUM_W'(sum);
      v.mn       = HW_W'(mn);
      v.mx       = HW_W'(mx);
      v.tog      = tog;
      return v;
   endfunction

   vec_t vecs [6];
   vec_t exp_q [$];

   // Returns at the negedge of the ARM cycle, with cfg inputs flipped to prove latching.
   task automatic start_burst(input vec_t v, input bit push);
      for (int i = 0; i < 4; i++) rise_tab[i] = v.rise[i];
      rise_len = v.rise_len;
      fall_val = v.fall;
      if (push) exp_q.push_back(v);
      cfg_log2_samples = v.k;
      cfg_src          = v.src;
      cfg_bypass       = v.byp;
      cfg_both_edges   = v.both;
      start            = 1'b1;
      @(negedge clk);
      start            = 1'b0;
      cfg_log2_samples = ~v.k;
      cfg_src          = ~v.src;
      cfg_bypass       = ~v.byp;
      cfg_both_edges   = ~v.both;
   endtask

   task automatic wait_result(output vec_t e);
      int n;
      n = 0;
      while (res_valid !== 1'b1 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check("res_valid_within_budget", res_valid, 1);
      check("scoreboard_depth", exp_q.size(), 1);
      e = vecs[0];
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("res_sum", res_sum, e.sum);
         check("res_min", res_min, e.mn);
         check("res_max", res_max, e.mx);
         check("tog_pulses", tog_cnt, e.tog);
         check("tog_spacing_errors", spacing_err, 0);
         check("pg_src_latched", tdc_pg_src, e.src);
         check("pg_bypass_latched", tdc_pg_bypass, e.byp);
         check("done_tdc_en", tdc_en, 0);
         check("done_busy", busy, 1);
      end
   endtask

   task automatic release_result();
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("after_ready_valid", res_valid, 0);
      check("after_ready_busy", busy, 0);
   endtask

   vec_t e;
   int   hold_err;
   int   seen;
   int   n;
   int   valid_seen;

   initial begin
      vecs[0] = mk(2,  1, 1, 0, 40, 40, 40, 40, 1, 24,   160, 40, 40,   4);
      vecs[1] = mk(3,  0, 0, 1, 10, 12, 11,  9, 4, 60,    84,  9, 12,  15);
      vecs[2] = mk(0,  1, 1, 1, 33, 33, 33, 33, 1,  5,    33, 33, 33,   1);
      vecs[3] = mk(1,  1, 0, 0, 50, 50, 50, 50, 1, 30,    84, 34, 50,   2);
      vecs[4] = mk(2,  1, 1, 1,  0,  0,  0,  0, 1,  0,   128,  0, 64,   4);
      vecs[5] = mk(15, 0, 0, 1, 64, 64, 64, 64, 1, 64, 16384, 64, 64, 511);

      // NOTE: bench stimulus uses blocking assignments at the negedge, well away
      // from the posedge where the design samples it.
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b0;
      cfg_log2_samples = 4'd0; cfg_src = 1'b0; cfg_bypass = 1'b0; cfg_both_edges = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ctrl_outs", {busy, tdc_en, tdc_pg_src, tdc_pg_bypass, tdc_pg_tog, res_valid}, 0);
      check("rst_sum", res_sum, 0);
      check("rst_min", res_min, 0);
      check("rst_max", res_max, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // First burst: ARM/LAUNCH timing, then a held-off handshake with a stray start.
      start_burst(vecs[0], 1'b1);
      check("arm_tdc_en", tdc_en, 1);
      check("arm_busy", busy, 1);
      check("arm_no_tog", tdc_pg_tog, 0);
      @(negedge clk);
      check("launch_tog", tdc_pg_tog, 1);
      wait_result(e);
      hold_err = 0;
      for (int i = 0; i < 20; i++) begin
         start = (i == 10);
         @(negedge clk);
         if (res_valid !== 1'b1 || busy !== 1'b1 || res_sum !== e.sum ||
             res_min !== e.mn || res_max !== e.mx) hold_err++;
      end
      start = 1'b0;
      check("done_hold_stable", hold_err, 0);
      release_result();
      check("idle_sum_readable", res_sum, e.sum);
      @(negedge clk);
      check("done_start_ignored", busy, 0);

      for (int i = 1; i < 6; i++) begin
         start_burst(vecs[i], 1'b1);
         wait_result(e);
         release_result();
      end

      // Abort in the WAIT phase of the second launch.
      start_burst(vecs[0], 1'b0);
      seen = 0; n = 0;
      while (seen < 2 && n < 200) begin
         @(negedge clk);
         n++;
         if (tdc_pg_tog === 1'b1) seen++;
      end
      check("abort_reached_launch2", seen, 2);
      repeat (2) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_tdc_en", tdc_en, 0);
      check("abort_tog", tdc_pg_tog, 0);
      valid_seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (res_valid !== 1'b0 || tdc_pg_tog !== 1'b0) valid_seen++;
      end
      check("abort_no_result", valid_seen, 0);

      // abort wins over start in IDLE.
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("abort_start_idle", busy, 0);

      start_burst(vecs[3], 1'b1);
      wait_result(e);
      release_result();

      // Asynchronous reset in the middle of the first SAMPLE cycle.
      start_burst(vecs[2], 1'b0);
      n = 0;
      while (tdc_pg_tog !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("rst_test_saw_launch", tdc_pg_tog, 1);
      repeat (LAT + 1) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_ctrl_outs", {busy, tdc_en, tdc_pg_src, tdc_pg_bypass, tdc_pg_tog, res_valid}, 0);
      check("async_rst_sum", res_sum, 0);
      check("async_rst_min", res_min, 0);
      check("async_rst_max", res_max, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start_burst(vecs[1], 1'b1);
      wait_result(e);
      release_result();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
